// File: rtl/seq_mult8_if.sv
// ----------------------------------------------------------------------------
// seq_mult8_if
// Start/done handshake bundle for the seq_mult8 sequential multiplier.
//   start    : request a multiply (master -> slave)
//   A, B     : 8-bit unsigned multiplicand / multiplier (master -> slave)
//   busy     : multiplier is iterating (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
//   P        : 16-bit product, held until the next completion (slave -> master)
// With SEQ_MULT8_ACC_EN defined the bundle also carries:
//   acc_clr  : on accept, 1 starts from zero, 0 accumulates onto P (master -> slave)
//   ovf      : sticky accumulate-overflow flag (slave -> master)
// ----------------------------------------------------------------------------
interface seq_mult8_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] P;
`ifdef SEQ_MULT8_ACC_EN
    logic        acc_clr;
    logic        ovf;

    modport master (output start, output A, output B, output acc_clr,
                    input  busy,  input  done, input  P, input  ovf);
    modport slave  (input  start, input  A, input  B, input  acc_clr,
                    output busy,  output done, output P, output ovf);
`else
    modport master (output start, output A, output B,
                    input  busy,  input  done, input  P);
    modport slave  (input  start, input  A, input  B,
                    output busy,  output done, output P);
`endif
endinterface

// File: rtl/seq_mult8.sv
// ----------------------------------------------------------------------------
// seq_mult8
// Sequential 8x8 unsigned shift-add multiplier with a 16-bit product. A single
// CLA16 carry-lookahead adder (defined below) performs one partial-product
// addition per clock, so a multiply takes at most 8 RUN steps plus one DONE
// cycle.
//
// Parameters:
//   SKIP_ZERO : 1 = leave RUN as soon as the remaining multiplier bits are all
//               zero; 0 = always run exactly 8 steps.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_mult8_if.slave (start, A, B, busy, done, P [, acc_clr, ovf])
// Build option:
//   SEQ_MULT8_ACC_EN : multiply-accumulate mode. acc_clr selects whether a new
//                      multiply starts from 0 or from the previous P; ovf is a
//                      sticky flag set by any adder carry-out. P wraps mod 2^16.
// ----------------------------------------------------------------------------

// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second
// lookahead level over the group generate/propagate terms.
module cla16 (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_cin,
    output logic [15:0] o_s,
    output logic        o_co
);
    // Flattened 4-bit lookahead: carry out of each bit position given c0.
    function automatic logic [3:0] cla4_carry(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       c0);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [15:0] w_g;
    logic [15:0] w_p;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // Group terms, second-level group carries, then per-bit carries and sum.
    always_comb begin
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [3:0]  gc;
        logic [3:0]  t;
        logic [4:0]  cv;
        logic [15:0] c;
        gg = 4'h0;
        gp = 4'h0;
        t  = 4'h0;
        c  = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            // A group's generate is its carry-out with no carry in.
            t     = cla4_carry(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0);
            gg[k] = t[3];
            gp[k] = &w_p[4*k +: 4];
        end
        gc = cla4_carry(gg, gp, i_cin);
        cv = {gc, i_cin};
        for (int k = 0; k < 4; k++) begin
            t            = cla4_carry(w_g[4*k +: 4], w_p[4*k +: 4], cv[k]);
            c[4*k +: 4]  = {t[2:0], cv[k]};
        end
        o_s  = w_p ^ c;
        o_co = gc[3];
    end
endmodule

module seq_mult8 #(
    parameter int SKIP_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_mult8_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_p;
`ifdef SEQ_MULT8_ACC_EN
    logic        r_ovf;
`endif

    logic [15:0] w_y;
    logic [15:0] w_sum;
    logic        w_co;
    logic        w_skip;
    logic        w_exit;

    // Partial product for this step: the shifted multiplicand when the current
    // multiplier bit is set.
    assign w_y    = r_mplier[0] ? r_mcand : 16'h0000;
    assign w_skip = (SKIP_ZERO != 0);
    // Last step: eighth iteration, or (early-exit build) nothing left to add
    // after this step.
    assign w_exit = (r_cnt == 3'd7) || (w_skip && (r_mplier[7:1] == 7'd0));

    cla16 u_cla16 (
        .i_x   (r_acc),
        .i_y   (w_y),
        .i_cin (1'b0),
        .o_s   (w_sum),
        .o_co  (w_co)
    );

`ifndef SEQ_MULT8_ACC_EN
    // An 8x8 product always fits in 16 bits, so the carry-out cannot fire here.
    logic w_unused_co;
    assign w_unused_co = w_co;
`endif

    // Control FSM and datapath registers, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mcand  <= 16'h0000;
            r_mplier <= 8'h00;
            r_acc    <= 16'h0000;
            r_cnt    <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= 16'h0000;
`ifdef SEQ_MULT8_ACC_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // done is a single-cycle pulse out of DONE.
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= {8'h00, bus.A};
                        r_mplier <= bus.B;
`ifdef SEQ_MULT8_ACC_EN
                        r_acc    <= bus.acc_clr ? 16'h0000 : r_p;
                        if (bus.acc_clr) begin
                            r_ovf <= 1'b0;
                        end
`else
                        r_acc    <= 16'h0000;
`endif
                        r_cnt    <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start is ignored here; A/B were captured on accept.
                    r_acc    <= w_sum;
                    r_mcand  <= {r_mcand[14:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[7:1]};
                    r_cnt    <= r_cnt + 3'd1;
`ifdef SEQ_MULT8_ACC_EN
                    if (w_co) begin
                        r_ovf <= 1'b1;
                    end
`endif
                    if (w_exit) begin
                        r_p     <= w_sum;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.P    = r_p;
`ifdef SEQ_MULT8_ACC_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_seq_mult8.sv
// ----------------------------------------------------------------------------
// tb_seq_mult8
// Two multipliers (early-exit and fixed 8-step) receive identical stimulus.
// The driver pushes each accepted operation's expected product, latency and
// overflow flag into a per-instance queue; a monitor pops and compares on
// every done pulse.
// ----------------------------------------------------------------------------
module tb_seq_mult8;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_mult8_if if_s ();
    seq_mult8_if if_f ();

    seq_mult8 #(.SKIP_ZERO(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    seq_mult8 #(.SKIP_ZERO(0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));

    typedef struct {
        logic [15:0] p;
        int          lat;
        int          acc_cyc;
        logic        ovf;
    } exp_t;

    exp_t        q_s[$];
    exp_t        q_f[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          bcnt_s   = 0;
    int          bcnt_f   = 0;
    logic [15:0] m_prev;
    logic        m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference latency: 8 steps, or with early exit the position of the
    // highest set multiplier bit (at least one step).
    function automatic int lat_of(input logic [7:0] b, input bit skip);
        int h;
        if (!skip) return 8;
        h = 0;
        for (int i = 0; i < 8; i++) if (b[i]) h = i + 1;
        return (h < 1) ? 1 : h;
    endfunction

    task automatic mon(input bit full, input logic done, input logic busy,
                       input logic [15:0] p
`ifdef SEQ_MULT8_ACC_EN
                       , input logic ovf
`endif
                       );
        exp_t  e;
        int    bc;
        string tag;
        tag = full ? "full" : "skip";
        if (!rst_n) begin
            if (full) bcnt_f = 0; else bcnt_s = 0;
            return;
        end
        bc = full ? bcnt_f : bcnt_s;
        if (done === 1'b1) begin
            if ((full ? q_f.size() : q_s.size()) == 0) begin
                n_checks++;
                $display("FAIL %s_unexpected_done: got done=1, expected no pending operation", tag);
            end else begin
                if (full) e = q_f.pop_front(); else e = q_s.pop_front();
                check({tag, "_P"}, {16'h0000, p}, {16'h0000, e.p});
                check({tag, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
                check({tag, "_busy_cycles"}, 32'(bc), 32'(e.lat));
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef SEQ_MULT8_ACC_EN
                check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
            bc = 0;
        end else if (busy === 1'b1) begin
            bc++;
        end
        if (full) bcnt_f = bc; else bcnt_s = bc;
    endtask

    // Monitor: sample both instances just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        mon(1'b0, if_s.done, if_s.busy, if_s.P
`ifdef SEQ_MULT8_ACC_EN
            , if_s.ovf
`endif
            );
        mon(1'b1, if_f.done, if_f.busy, if_f.P
`ifdef SEQ_MULT8_ACC_EN
            , if_f.ovf
`endif
            );
    end

    // Issue one multiply (instances must be idle or in DONE) and record expectations.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
        exp_t        e;
        logic [16:0] sum;
        logic [15:0] base;
        logic        ov_base;
        @(negedge clk);
        if_s.A = a; if_f.A = a;
        if_s.B = b; if_f.B = b;
        if_s.start = 1'b1; if_f.start = 1'b1;
`ifdef SEQ_MULT8_ACC_EN
        if_s.acc_clr = clr; if_f.acc_clr = clr;
        base    = clr ? 16'h0000 : m_prev;
        ov_base = clr ? 1'b0 : m_ovf;
`else
        base    = clr ? 16'h0000 : 16'h0000;
        ov_base = 1'b0;
`endif
        @(posedge clk);
        #1;
        sum       = {1'b0, base} + ({9'h000, a} * {9'h000, b});
        e.p       = sum[15:0];
        e.ovf     = ov_base | sum[16];
        e.acc_cyc = cyc;
        m_prev    = e.p;
        m_ovf     = e.ovf;
        e.lat     = lat_of(b, 1'b1);
        q_s.push_back(e);
        e.lat     = lat_of(b, 1'b0);
        q_f.push_back(e);
        @(negedge clk);
        if_s.start = 1'b0; if_f.start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (q_s.size() == 0 && q_f.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check(name, 32'(q_s.size() + q_f.size()), 32'd0);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_busy"}, {30'd0, if_s.busy, if_f.busy}, 32'd0);
        check({name, "_done"}, {30'd0, if_s.done, if_f.done}, 32'd0);
        check({name, "_P"}, {if_s.P, if_f.P}, 32'd0);
`ifdef SEQ_MULT8_ACC_EN
        check({name, "_ovf"}, {30'd0, if_s.ovf, if_f.ovf}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        rst_n = 1'b1;
        if_s.start = 1'b0; if_f.start = 1'b0;
        if_s.A = 8'h00; if_f.A = 8'h00;
        if_s.B = 8'h00; if_f.B = 8'h00;
`ifdef SEQ_MULT8_ACC_EN
        if_s.acc_clr = 1'b1; if_f.acc_clr = 1'b1;
`endif
        m_prev = 16'h0000;
        m_ovf  = 1'b0;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #12;
        rst_n = 1'b0;
        #1;
        check_cleared("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full run 0x0F*0x0F.
        do_op(8'h0F, 8'h0F, 1'b1);
        drain("drain_0f");

        // Max operands, then back-to-back start in the DONE cycle.
        do_op(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (if_f.done === 1'b1) break;
        end
        check("b2b_done_seen", {31'd0, if_f.done}, 32'd1);
        do_op(8'h12, 8'h34, 1'b1);
        drain("drain_b2b");

        // Early exit cases.
        do_op(8'hAB, 8'h00, 1'b1);
        drain("drain_b0");
        do_op(8'h03, 8'h05, 1'b1);
        drain("drain_b5");

        // start during RUN is ignored.
        do_op(8'h10, 8'h80, 1'b1);
        @(negedge clk);
        if_s.A = 8'h01; if_f.A = 8'h01;
        if_s.B = 8'h01; if_f.B = 8'h01;
        if_s.start = 1'b1; if_f.start = 1'b1;
        @(negedge clk);
        if_s.start = 1'b0; if_f.start = 1'b0;
        drain("drain_ignored_start");

        // Reset in the middle of a multiply: everything cleared, no done.
        do_op(8'h10, 8'h80, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("reset_midop");
        q_s.delete();
        q_f.delete();
        m_prev = 16'h0000;
        m_ovf  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
            check_cleared("post_reset_idle");
        end

        // Accumulate sequence (plain products without the accumulate option).
        do_op(8'hFF, 8'hFF, 1'b1);
        drain("drain_acc1");
        do_op(8'hFF, 8'hFF, 1'b0);
        drain("drain_acc2");
        do_op(8'h01, 8'h01, 1'b1);
        drain("drain_acc3");

        // Randomized operands with a mix of multiplier widths.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = 8'($urandom_range(0, 3));
                1:       rb = 8'($urandom_range(0, 31));
                2:       rb = 8'($urandom_range(128, 255));
                default: rb = 8'($urandom_range(0, 255));
            endcase
            rc = ($urandom_range(0, 3) == 0);
            do_op(ra, rb, rc);
            drain("drain_random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_mult8.md
# seq_mult8

Sequential 8x8 unsigned shift-add multiplier producing a 16-bit product. It is the stage directly upstream of the datapath result bus and consumes the team's CLA16 16-bit carry-lookahead adder. One CLA16 instance performs every partial-product addition, one step per clock, so a multiply costs up to 8 iterations instead of a full array. It is controlled by a single start/done handshake.

## Interface
- SKIP_ZERO, default 1: 1 ends the multiply early once the remaining multiplier bits are all zero; 0 always runs exactly 8 iterations.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- start  input  1  request a multiply. Sampled only in IDLE or DONE.
- A  input  8  multiplicand, unsigned. Sampled on the edge that accepts start.
- B  input  8  multiplier, unsigned. Sampled on the edge that accepts start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; P is valid from this cycle onward.
- P  output  16  product register. Holds its value until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, P=16'h0000. All internal registers are 0.
- Accept: on an edge in IDLE or DONE with start=1:
  - mcand <= {8'h00,A}
  - mplier <= B
  - acc <= 16'h0000
  - cnt <= 0
  - state <= RUN
- start in RUN is ignored. A and B are not re-sampled.
- RUN step, each edge:
  - CLA16 operands are X=acc, Y=(mplier[0] ? mcand : 16'h0000), Cin=0.
  - acc <= S
  - mcand <= mcand<<1
  - mplier <= mplier>>1
  - cnt <= cnt+1
- RUN exit: leave RUN when cnt==7, or when SKIP_ZERO=1 and (mplier>>1)==0.
  - On that edge: P <= S, state <= DONE.
- DONE lasts exactly one cycle (done=1, busy=0).
  - start=1 in DONE is accepted: back-to-back operation, no IDLE bubble.
  - Otherwise the next state is IDLE.
- Width rule: the 8x8 product never exceeds 16 bits, so Co is unused in the base build.
- Reset mid-operation: all state is cleared immediately. The partial product is discarded and P returns to 0.

## Timing
- Edge 0 accepts start. busy=1 after edge 0.
- Full-length multiply (SKIP_ZERO=0, or B[7]=1):
  - RUN steps occur on edges 1..8.
  - done=1 and P valid after edge 8, i.e. 8 cycles after acceptance.
  - busy falls in the same cycle that done rises.
- Early exit (SKIP_ZERO=1): latency is max(1, index of highest set bit of B + 1) cycles.
  - B=0 or B=1: done after edge 1.
- The adder path is CLA16 combinational delay plus the acc register. No multicycle paths.
- Throughput: one result per 9 cycles worst case, including the DONE cycle.

## Configuration
- Macro: SEQ_MULT8_ACC_EN.
- Defined: multiply-accumulate mode, with extra ports acc_clr (input 1) and ovf (output 1).
  - On accept with acc_clr=1: acc <= 0 and ovf is cleared.
  - On accept with acc_clr=0: acc <= P, so the new product is added to the previous result.
  - ovf is a sticky flag. It sets on any RUN step where CLA16 Co=1. Reset value 0.
  - P wraps modulo 2^16.
- Undefined: acc_clr and ovf do not exist, and acc always starts at 0.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> busy=0, done=0, P=0x0000 immediately, with no clock edge needed.
- Full run: SKIP_ZERO=0, A=0x0F, B=0x0F, start -> done on the 8th edge after acceptance, P=0x00E1; busy high for exactly 8 cycles.
- Max operands: A=0xFF, B=0xFF -> P=0xFE01 after 8 cycles. Then immediately start with A=0x12, B=0x34 in the DONE cycle -> P=0x03A8 with no idle gap.
- Early exit: SKIP_ZERO=1, A=0xAB, B=0x00 -> done after 1 cycle, P=0x0000. Then A=0x03, B=0x05 -> done after 3 cycles, P=0x000F.
- Ignored start / reset mid-op: start with A=0x10, B=0x80 (SKIP_ZERO=1); pulse start with A=0x01, B=0x01 in cycle 3 -> final P=0x0800. Repeat the multiply and drop rst_n in cycle 4 -> P=0, state IDLE, and no done pulse.
- ACC (SEQ_MULT8_ACC_EN defined):
  - Run 0xFF*0xFF with acc_clr=1 -> P=0xFE01, ovf=0.
  - Then 0xFF*0xFF with acc_clr=0 -> P=0xFC02, ovf=1.
  - Then 0x01*0x01 with acc_clr=1 -> P=0x0001, ovf=0.
